// File: rtl/sm_cp0_pkg.sv
// Shared constants for the schoolMIPS Coprocessor 0: register map, exception
// codes, Status/Cause field positions and handler vector offsets.
package sm_cp0_pkg;

  localparam int REG_NUM_W = 5;
  localparam int REG_SEL_W = 3;

  // Register numbers (all live on select 0)
  localparam logic [REG_NUM_W-1:0] REG_COUNT   = 5'd9;
  localparam logic [REG_NUM_W-1:0] REG_COMPARE = 5'd11;
  localparam logic [REG_NUM_W-1:0] REG_STATUS  = 5'd12;
  localparam logic [REG_NUM_W-1:0] REG_CAUSE   = 5'd13;
  localparam logic [REG_NUM_W-1:0] REG_EPC     = 5'd14;
  localparam logic [REG_SEL_W-1:0] REG_SEL_MAIN = 3'd0;

  // Cause.ExcCode values
  typedef enum logic [4:0] {
    EXC_INT = 5'h00,
    EXC_SYS = 5'h08,
    EXC_RI  = 5'h0a,
    EXC_OV  = 5'h0c
  } excCode_t;

  // Status field positions
  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LSB = 8;

  // Cause field positions
  localparam int CAUSE_TI      = 30;
  localparam int CAUSE_DC      = 27;
  localparam int CAUSE_IV      = 23;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_EXC_LSB = 2;

  // Handler offsets from the exception base
  localparam logic [31:0] VEC_GENERAL_OFS = 32'h0000_0180;
  localparam logic [31:0] VEC_IRQ_OFS     = 32'h0000_0200;

  // Index of the most significant set bit (0 when nothing is set)
  function automatic logic [2:0] highestSetBit(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sm_cp0_ext_if.sv
// Core <-> CP0 bus: mtc0/mfc0 access, exception sources and fetch redirect.
// master = datapath side, slave = coprocessor side.
interface sm_cp0_ext_if #(
  parameter int HW_IRQ_NUM = 5
);
  import sm_cp0_pkg::*;

  logic [31:0]           cp0_PC;
  logic [31:0]           cp0_EPC;
  logic [31:0]           cp0_ExcHandler;
  logic                  cp0_ExcRequest;
  logic                  cp0_ExcEret;
  logic [REG_NUM_W-1:0]  cp0_regNum;
  logic [REG_SEL_W-1:0]  cp0_regSel;
  logic [31:0]           cp0_regRD;
  logic [31:0]           cp0_regWD;
  logic                  cp0_regWE;
  logic [HW_IRQ_NUM-1:0] cp0_ExcIP;
  logic                  cp0_ExcRI;
  logic                  cp0_ExcSys;
  logic                  cp0_ExcOv;
  logic                  cp0_TimerIrq;

  modport master (
    output cp0_PC, cp0_ExcEret, cp0_regNum, cp0_regSel, cp0_regWD, cp0_regWE,
           cp0_ExcIP, cp0_ExcRI, cp0_ExcSys, cp0_ExcOv,
    input  cp0_EPC, cp0_ExcHandler, cp0_ExcRequest, cp0_regRD, cp0_TimerIrq
  );

  modport slave (
    input  cp0_PC, cp0_ExcEret, cp0_regNum, cp0_regSel, cp0_regWD, cp0_regWE,
           cp0_ExcIP, cp0_ExcRI, cp0_ExcSys, cp0_ExcOv,
    output cp0_EPC, cp0_ExcHandler, cp0_ExcRequest, cp0_regRD, cp0_TimerIrq
  );

endinterface

// File: rtl/sm_cp0_timer.sv
// Count/Compare timer: prescaler, free-running Count, Compare and the sticky
// timer interrupt flag TI. Software writes take priority over the counters.
module sm_cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        countWe,
  input  logic        compareWe,
  input  logic [31:0] writeData,
  input  logic        dc,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PRESC_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(COUNT_DIV - 1);

  logic [PRESC_W-1:0] prescReg;
  logic [31:0]        countReg;
  logic [31:0]        compareReg;
  logic               tiReg;
  logic               prescWrap;

  assign prescWrap = (prescReg == PRESC_LAST);

  // Prescaler: restarts on a Count write, frozen while Count is disabled
  always_ff @(posedge clk) begin
    if (rst || countWe) begin
      prescReg <= '0;
    end else if (!dc) begin
      prescReg <= prescWrap ? '0 : prescReg + 1'b1;
    end
  end

  // Count: a software write beats a same-cycle increment; wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      countReg <= '0;
    end else if (countWe) begin
      countReg <= writeData;
    end else if (!dc && prescWrap) begin
      countReg <= countReg + 32'd1;
    end
  end

  // Compare register
  always_ff @(posedge clk) begin
    if (rst) begin
      compareReg <= '0;
    end else if (compareWe) begin
      compareReg <= writeData;
    end
  end

  // TI: sticky on match, cleared only by writing Compare (the write wins)
  always_ff @(posedge clk) begin
    if (rst || compareWe) begin
      tiReg <= 1'b0;
    end else if (!dc && (countReg == compareReg)) begin
      tiReg <= 1'b1;
    end
  end

  assign count   = countReg;
  assign compare = compareReg;
  assign ti      = tiReg;

endmodule

// File: rtl/sm_cp0_ext.sv
// schoolMIPS Coprocessor 0: Status/Cause/EPC, hardware interrupt sampling,
// exception prioritisation and handler (optionally vectored) generation.
module sm_cp0_ext
  import sm_cp0_pkg::*;
#(
  parameter int          HW_IRQ_NUM  = 5,
  parameter logic [31:0] EXC_BASE    = 32'h0000_0000,
  parameter int          VEC_SPACING = 32,
  parameter int          COUNT_DIV   = 2
) (
  input logic         clk,
  input logic         rst,
  sm_cp0_ext_if.slave cp0
);

  localparam logic [31:0] VEC_SPACING_W = 32'(VEC_SPACING);

  // Architectural state
  logic [7:0]  statusIm;
  logic        statusExl;
  logic        statusIe;
  logic        causeDc;
  logic        causeIv;
  logic [1:0]  causeSwIp;
  logic [4:0]  hwIpReg;
  excCode_t    excCodeReg;
  logic [31:0] epcReg;
  logic [31:0] handlerReg;
  logic        excRequestReg;

  // Timer interface
  logic [31:0] countVal;
  logic [31:0] compareVal;
  logic        timerIrq;

  // Decoded writes
  logic wrMain, countWe, compareWe, statusWe, causeWe, epcWe;

  assign wrMain    = cp0.cp0_regWE && (cp0.cp0_regSel == REG_SEL_MAIN);
  assign countWe   = wrMain && (cp0.cp0_regNum == REG_COUNT);
  assign compareWe = wrMain && (cp0.cp0_regNum == REG_COMPARE);
  assign statusWe  = wrMain && (cp0.cp0_regNum == REG_STATUS);
  assign causeWe   = wrMain && (cp0.cp0_regNum == REG_CAUSE);
  assign epcWe     = wrMain && (cp0.cp0_regNum == REG_EPC);

  sm_cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) timer (
    .clk       (clk),
    .rst       (rst),
    .countWe   (countWe),
    .compareWe (compareWe),
    .writeData (cp0.cp0_regWD),
    .dc        (causeDc),
    .count     (countVal),
    .compare   (compareVal),
    .ti        (timerIrq)
  );

  // Hardware lines map to IP[2+i]; lines beyond HW_IRQ_NUM are tied low
  logic [4:0] hwIpIn;
  for (genvar gi = 0; gi < 5; gi++) begin : gHwIp
    if (gi < HW_IRQ_NUM) begin : gUsed
      assign hwIpIn[gi] = cp0.cp0_ExcIP[gi];
    end else begin : gUnused
      assign hwIpIn[gi] = 1'b0;
    end
  end

  // Sample hardware interrupt levels every cycle (not latched)
  always_ff @(posedge clk) begin
    if (rst) hwIpReg <= '0;
    else     hwIpReg <= hwIpIn;
  end

  logic [7:0] causeIp;
  logic [7:0] maskedIp;
  logic       intPending;

  assign causeIp    = {timerIrq, hwIpReg, causeSwIp};
  assign maskedIp   = causeIp & statusIm;
  assign intPending = statusIe && !statusExl && (|maskedIp);

  // Exception priority RI > Sys > Ov > Int, plus the handler it will use
  logic        excDetect;
  excCode_t    excCode;
  logic [31:0] handlerNext;
  logic [2:0]  irqIndex;

  always_comb begin
    excDetect   = 1'b0;
    excCode     = EXC_INT;
    irqIndex    = highestSetBit(maskedIp);
    handlerNext = EXC_BASE + VEC_GENERAL_OFS;
    if (cp0.cp0_ExcRI) begin
      excDetect = 1'b1;
      excCode   = EXC_RI;
    end else if (cp0.cp0_ExcSys) begin
      excDetect = 1'b1;
      excCode   = EXC_SYS;
    end else if (cp0.cp0_ExcOv) begin
      excDetect = 1'b1;
      excCode   = EXC_OV;
    end else if (intPending) begin
      excDetect = 1'b1;
      excCode   = EXC_INT;
      if (causeIv) begin
        handlerNext = EXC_BASE + VEC_IRQ_OFS + VEC_SPACING_W * {29'd0, irqIndex};
      end
    end
  end

  // Status: exception entry forces EXL even against a same-cycle write or eret
  always_ff @(posedge clk) begin
    if (rst) begin
      statusIm  <= '0;
      statusIe  <= 1'b0;
      statusExl <= 1'b0;
    end else begin
      if (statusWe) begin
        statusIm <= cp0.cp0_regWD[STATUS_IM_LSB +: 8];
        statusIe <= cp0.cp0_regWD[STATUS_IE];
      end
      if (excDetect)             statusExl <= 1'b1;
      else if (cp0.cp0_ExcEret)  statusExl <= 1'b0;
      else if (statusWe)         statusExl <= cp0.cp0_regWD[STATUS_EXL];
    end
  end

  // Cause: software may only touch IP[1:0], DC and IV; ExcCode tracks exceptions
  always_ff @(posedge clk) begin
    if (rst) begin
      causeDc    <= 1'b0;
      causeIv    <= 1'b0;
      causeSwIp  <= '0;
      excCodeReg <= EXC_INT;
    end else begin
      if (causeWe) begin
        causeDc   <= cp0.cp0_regWD[CAUSE_DC];
        causeIv   <= cp0.cp0_regWD[CAUSE_IV];
        causeSwIp <= cp0.cp0_regWD[CAUSE_IP_LSB +: 2];
      end
      if (excDetect) excCodeReg <= excCode;
    end
  end

  // EPC: captured only on a first-level exception so nested faults keep it
  always_ff @(posedge clk) begin
    if (rst) begin
      epcReg <= '0;
    end else if (excDetect && !statusExl) begin
      epcReg <= cp0.cp0_PC;
    end else if (epcWe) begin
      epcReg <= cp0.cp0_regWD;
    end
  end

  // One-cycle request strobe; handler address held until the next exception
  always_ff @(posedge clk) begin
    if (rst) begin
      excRequestReg <= 1'b0;
      handlerReg    <= '0;
    end else begin
      excRequestReg <= excDetect;
      if (excDetect) handlerReg <= handlerNext;
    end
  end

  // mfc0 read mux, combinational from register state
  logic [31:0] readData;
  always_comb begin
    readData = '0;
    if (cp0.cp0_regSel == REG_SEL_MAIN) begin
      case (cp0.cp0_regNum)
        REG_COUNT:   readData = countVal;
        REG_COMPARE: readData = compareVal;
        REG_STATUS: begin
          readData[STATUS_IM_LSB +: 8] = statusIm;
          readData[STATUS_EXL]         = statusExl;
          readData[STATUS_IE]          = statusIe;
        end
        REG_CAUSE: begin
          readData[CAUSE_TI]              = timerIrq;
          readData[CAUSE_DC]              = causeDc;
          readData[CAUSE_IV]              = causeIv;
          readData[CAUSE_IP_LSB +: 8]     = causeIp;
          readData[CAUSE_EXC_LSB +: 5]    = excCodeReg;
        end
        REG_EPC:     readData = epcReg;
        default:     readData = '0;
      endcase
    end
  end

  assign cp0.cp0_regRD      = readData;
  assign cp0.cp0_EPC        = epcReg;
  assign cp0.cp0_ExcHandler = handlerReg;
  assign cp0.cp0_ExcRequest = excRequestReg;
  assign cp0.cp0_TimerIrq   = timerIrq;

endmodule

// File: tb/tb_sm_cp0_ext.sv
// Self-checking bench for sm_cp0_ext: exception strobes are scoreboarded
// (expected handler/code/cycle queued at stimulus time, popped when the DUT
// raises cp0_ExcRequest); register reads go through a read queue.
module tb_sm_cp0_ext;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    int          cyc;
    logic [31:0] handler;
    logic [4:0]  code;
  } excExp_t;

  excExp_t     excQ[$];
  logic [31:0] rdQ[$];

  sm_cp0_ext_if #(.HW_IRQ_NUM(5)) bus ();

  sm_cp0_ext #(
    .HW_IRQ_NUM  (5),
    .EXC_BASE    (32'h0000_0000),
    .VEC_SPACING (32),
    .COUNT_DIV   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cp0 (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectExc(input int atCyc, input logic [31:0] handler, input logic [4:0] code);
    excExp_t e;
    e.cyc = atCyc;
    e.handler = handler;
    e.code = code;
    excQ.push_back(e);
  endtask

  task automatic rd(input string tag, input logic [4:0] num, input logic [31:0] exp);
    logic [31:0] e;
    rdQ.push_back(exp);
    bus.cp0_regNum = num;
    bus.cp0_regSel = 3'd0;
    #1;
    e = rdQ.pop_front();
    $display("READ  reg=%0d data=%h", num, bus.cp0_regRD);
    checkVal(tag, bus.cp0_regRD, e);
  endtask

  task automatic wr(input logic [4:0] num, input logic [31:0] data);
    bus.cp0_regNum = num;
    bus.cp0_regSel = 3'd0;
    bus.cp0_regWD  = data;
    bus.cp0_regWE  = 1'b1;
    tick();
    bus.cp0_regWE  = 1'b0;
    $display("WRITE reg=%0d data=%h", num, data);
  endtask

  task automatic irqPulse(input logic [31:0] handler);
    bus.cp0_ExcIP = 5'b00001;
    expectExc(cyc + 2, handler, 5'h00);
    tick();
    bus.cp0_ExcIP = '0;
    tick();
    tick();
  endtask

  task automatic eret();
    bus.cp0_ExcEret = 1'b1;
    tick();
    bus.cp0_ExcEret = 1'b0;
    $display("ERET");
  endtask

  // Scoreboard: every strobe must match the oldest expectation
  always @(negedge clk) begin
    excExp_t e;
    if (bus.cp0_ExcRequest === 1'b1) begin
      $display("EXC   cyc=%0d handler=%h code=%h", cyc, bus.cp0_ExcHandler, dut.excCodeReg);
      if (excQ.size() == 0) begin
        checkVal("spurious_req", {31'd0, bus.cp0_ExcRequest}, 32'd0);
      end else begin
        e = excQ.pop_front();
        checkVal("exc_cycle", cyc, e.cyc);
        checkVal("exc_handler", bus.cp0_ExcHandler, e.handler);
        checkVal("exc_code", {27'd0, dut.excCodeReg}, {27'd0, e.code});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.cp0_PC = '0;      bus.cp0_ExcEret = 1'b0;
    bus.cp0_regNum = '0;  bus.cp0_regSel = '0;
    bus.cp0_regWD = '0;   bus.cp0_regWE = 1'b0;
    bus.cp0_ExcIP = '0;   bus.cp0_ExcRI = 1'b0;
    bus.cp0_ExcSys = 1'b0; bus.cp0_ExcOv = 1'b0;
    repeat (3) tick();

    // Reset state
    checkVal("rst_req", {31'd0, bus.cp0_ExcRequest}, 32'd0);
    checkVal("rst_handler", bus.cp0_ExcHandler, 32'd0);
    checkVal("rst_timerirq", {31'd0, bus.cp0_TimerIrq}, 32'd0);
    rd("rst_count", 5'd9, 32'd0);
    rd("rst_compare", 5'd11, 32'd0);
    rd("rst_status", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
    rst = 1'b0;
    tick();

    // Count write and prescaled increment (COUNT_DIV=2)
    wr(5'd9, 32'h0000_1234);
    rd("count_wr", 5'd9, 32'h0000_1234);
    repeat (10) tick();
    rd("count_inc", 5'd9, 32'h0000_1239);

    // Timer interrupt: Compare=5, Count=0 -> match after 10 edges, TI one later
    wr(5'd11, 32'd5);
    checkVal("ti_clr_cmp", {31'd0, bus.cp0_TimerIrq}, 32'd0);
    wr(5'd9, 32'd0);
    repeat (10) tick();
    rd("count_at_cmp", 5'd9, 32'd5);
    checkVal("ti_before", {31'd0, bus.cp0_TimerIrq}, 32'd0);
    tick();
    checkVal("ti_set", {31'd0, bus.cp0_TimerIrq}, 32'd1);
    rd("cause_ti", 5'd13, 32'h4000_8000);
    wr(5'd11, 32'hFFFF_0000);
    checkVal("ti_clr", {31'd0, bus.cp0_TimerIrq}, 32'd0);

    // Count wrap
    wr(5'd9, 32'hFFFF_FFFF);
    tick();
    tick();
    rd("count_wrap", 5'd9, 32'd0);

    // Hardware interrupt, non-vectored
    bus.cp0_PC = 32'h40;
    wr(5'd12, 32'h0000_0401);
    irqPulse(32'h180);
    rd("int_epc", 5'd14, 32'h40);
    rd("int_status", 5'd12, 32'h0000_0403);
    rd("int_cause", 5'd13, 32'h0);
    eret();
    rd("eret_status", 5'd12, 32'h0000_0401);

    // Vectored interrupt: IP2 -> 0x200 + 2*32
    wr(5'd13, 32'h0080_0000);
    bus.cp0_PC = 32'h80;
    irqPulse(32'h240);
    rd("iv_epc", 5'd14, 32'h80);
    checkVal("handler_held", bus.cp0_ExcHandler, 32'h240);
    eret();

    // RI+Sys+Ov with an interrupt pending -> RI
    bus.cp0_PC = 32'h100;
    bus.cp0_ExcIP = 5'b00001;
    tick();
    bus.cp0_ExcRI = 1'b1; bus.cp0_ExcSys = 1'b1; bus.cp0_ExcOv = 1'b1;
    expectExc(cyc + 1, 32'h180, 5'h0a);
    tick();
    bus.cp0_ExcRI = 1'b0; bus.cp0_ExcSys = 1'b0; bus.cp0_ExcOv = 1'b0;
    bus.cp0_ExcIP = '0;
    tick();
    rd("ri_epc", 5'd14, 32'h100);
    eret();

    // Sys+Ov with an interrupt pending -> Sys
    bus.cp0_PC = 32'h140;
    bus.cp0_ExcIP = 5'b00001;
    tick();
    bus.cp0_ExcSys = 1'b1; bus.cp0_ExcOv = 1'b1;
    expectExc(cyc + 1, 32'h180, 5'h08);
    tick();
    bus.cp0_ExcSys = 1'b0; bus.cp0_ExcOv = 1'b0;
    bus.cp0_ExcIP = '0;
    tick();
    rd("sys_epc", 5'd14, 32'h140);

    // Overflow while EXL=1: strobe and code update, EPC holds
    bus.cp0_PC = 32'h200;
    bus.cp0_ExcOv = 1'b1;
    expectExc(cyc + 1, 32'h180, 5'h0c);
    tick();
    bus.cp0_ExcOv = 1'b0;
    tick();
    rd("ov_epc_hold", 5'd14, 32'h140);
    rd("ov_cause", 5'd13, 32'h0080_0030);
    eret();
    rd("ov_eret", 5'd12, 32'h0000_0401);

    // Exception together with mtc0 Status: EXL=1, IE/IM from the write
    bus.cp0_PC = 32'h300;
    bus.cp0_ExcRI = 1'b1;
    expectExc(cyc + 1, 32'h180, 5'h0a);
    wr(5'd12, 32'h0000_0801);
    bus.cp0_ExcRI = 1'b0;
    rd("exc_vs_wr", 5'd12, 32'h0000_0803);
    rd("exc_vs_wr_epc", 5'd14, 32'h300);
    eret();
    rd("exc_vs_wr_eret", 5'd12, 32'h0000_0801);

    // Reset during the exception-pending cycle: no strobe, all clear
    bus.cp0_ExcRI = 1'b1;
    rst = 1'b1;
    tick();
    bus.cp0_ExcRI = 1'b0;
    rst = 1'b0;
    checkVal("mid_rst_req", {31'd0, bus.cp0_ExcRequest}, 32'd0);
    checkVal("mid_rst_handler", bus.cp0_ExcHandler, 32'd0);
    checkVal("mid_rst_timerirq", {31'd0, bus.cp0_TimerIrq}, 32'd0);
    rd("mid_rst_count", 5'd9, 32'd0);
    rd("mid_rst_compare", 5'd11, 32'd0);
    rd("mid_rst_status", 5'd12, 32'd0);
    rd("mid_rst_cause", 5'd13, 32'd0);
    rd("mid_rst_epc", 5'd14, 32'd0);
    tick();
    tick();

    checkVal("exc_queue_empty", 32'(excQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
